// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control stage and its helpers.
//   state_e      : control FSM states
//   field params : bit positions of the Hack C-instruction fields
//   J* params    : jump condition encodings (instr[2:0])
//   WORD_W/ADDR_W: data word and address widths
package hack_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 15;

  // Instruction field positions
  localparam int unsigned CI_BIT   = 15;  // 1 = C-instruction
  localparam int unsigned A_BIT    = 12;  // y operand select: 1 = M, 0 = A
  localparam int unsigned CTRL_MSB = 11;
  localparam int unsigned CTRL_LSB = 6;
  localparam int unsigned DEST_MSB = 5;   // d1 (A)
  localparam int unsigned DEST_LSB = 3;   // d3 (M)
  localparam int unsigned JMP_MSB  = 2;
  localparam int unsigned JMP_LSB  = 0;

  // Jump encodings {j1,j2,j3}
  localparam logic [2:0] JNULL = 3'b000;
  localparam logic [2:0] JGT   = 3'b001;
  localparam logic [2:0] JEQ   = 3'b010;
  localparam logic [2:0] JGE   = 3'b011;
  localparam logic [2:0] JLT   = 3'b100;
  localparam logic [2:0] JNE   = 3'b101;
  localparam logic [2:0] JLE   = 3'b110;
  localparam logic [2:0] JMP   = 3'b111;

  // Commit is not a held state: it happens on the edge that leaves DECODE
  // (A-instruction), EXEC (no M write) or MEM_WR (after the write ack).
  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StMemRd,
    StExec,
    StMemWr
  } state_e;

endpackage

// File: rtl/hack_jump_unit.sv
// Hack jump condition evaluator (purely combinational).
//   j    : jump bits {j1,j2,j3} from instr[2:0]
//   zr   : ALU result is zero
//   ng   : ALU result is negative
//   jump : 1 when the condition selected by j holds
module hack_jump_unit
  import hack_pkg::*;
(
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       jump
);

  logic pos;
  assign pos = ~zr & ~ng;

  // Each term follows (j1&ng) | (j2&zr) | (j3&pos) exactly, so odd flag
  // combinations (zr and ng both set) behave like the reference equation.
  always_comb begin
    jump = 1'b0;
    unique case (j)
      JNULL: jump = 1'b0;
      JGT:   jump = pos;
      JEQ:   jump = zr;
      JGE:   jump = zr | pos;
      JLT:   jump = ng;
      JNE:   jump = ng | pos;
      JLE:   jump = ng | zr;
      JMP:   jump = 1'b1;
    endcase
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control and register stage, upstream of hack_alu.
//   imem_*  : instruction fetch req/ack port (address = PC)
//   dmem_*  : data read/write req/ack port (address = A[14:0])
//   alu_*   : operands/control to the ALU and its result/flags back
//   retire  : one-cycle pulse, high the cycle after an instruction commits
//   pc_o    : current PC for debug
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 15'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              dmem_rd_req,
  output logic              dmem_wr_req,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic [WORD_W-1:0] alu_x,
  output logic [WORD_W-1:0] alu_y,
  output logic [5:0]        alu_ctrl,
  input  logic [WORD_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [WORD_W-1:0] a_q, d_q, instr_q, m_q, res_q;
  logic              zr_q, ng_q;

  logic              in_exec, commit, jump;
  logic [2:0]        dest;
  logic [WORD_W-1:0] cmt_res;
  logic              cmt_zr, cmt_ng;
  logic [ADDR_W-1:0] pc_inc;
  logic              unused_bits;

  assign unused_bits = ^instr_q[14:13];  // ignored by the Hack ISA
  assign dest        = instr_q[DEST_MSB:DEST_LSB];
  assign pc_inc      = pc_q + ADDR_W'(1);  // wraps 0x7FFF -> 0

  assign imem_addr = pc_q;
  assign pc_o      = pc_q;
  // A only changes at commit, so this is the instruction-start A throughout.
  assign dmem_addr = a_q[ADDR_W-1:0];
  assign alu_x     = d_q;
  assign alu_y     = instr_q[A_BIT] ? m_q : a_q;

  // Without an M write the commit edge is the EXEC exit, so the live ALU
  // result/flags are used; after MEM_WR the latched copies are used.
  assign in_exec = (state_q == StExec);
  assign commit  = (in_exec && !dest[0]) ||
                   (state_q == StMemWr && dmem_wr_req && dmem_ack);
  assign cmt_res = in_exec ? alu_out : res_q;
  assign cmt_zr  = in_exec ? alu_zr : zr_q;
  assign cmt_ng  = in_exec ? alu_ng : ng_q;

  hack_jump_unit u_jump (
    .j    (instr_q[JMP_MSB:JMP_LSB]),
    .zr   (cmt_zr),
    .ng   (cmt_ng),
    .jump (jump)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      a_q         <= '0;
      d_q         <= '0;
      instr_q     <= '0;
      m_q         <= '0;
      res_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      imem_req    <= 1'b0;
      dmem_rd_req <= 1'b0;
      dmem_wr_req <= 1'b0;
      dmem_wdata  <= '0;
      alu_ctrl    <= '0;
      retire      <= 1'b0;
    end else begin
      retire <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if (imem_req && imem_ack) begin
            instr_q  <= imem_rdata;
            imem_req <= 1'b0;
            state_q  <= StDecode;
          end else begin
            // Only reached low on the first cycle out of reset.
            imem_req <= 1'b1;
          end
        end
        StDecode: begin
          if (!instr_q[CI_BIT]) begin
            a_q      <= instr_q;
            pc_q     <= pc_inc;
            retire   <= 1'b1;
            imem_req <= 1'b1;
            state_q  <= StFetch;
          end else if (instr_q[A_BIT]) begin
            dmem_rd_req <= 1'b1;
            state_q     <= StMemRd;
          end else begin
            alu_ctrl <= instr_q[CTRL_MSB:CTRL_LSB];
            state_q  <= StExec;
          end
        end
        StMemRd: begin
          if (dmem_rd_req && dmem_ack) begin
            m_q         <= dmem_rdata;
            dmem_rd_req <= 1'b0;
            alu_ctrl    <= instr_q[CTRL_MSB:CTRL_LSB];
            state_q     <= StExec;
          end
        end
        StExec: begin
          res_q    <= alu_out;
          zr_q     <= alu_zr;
          ng_q     <= alu_ng;
          alu_ctrl <= '0;
          if (dest[0]) begin
            dmem_wr_req <= 1'b1;
            dmem_wdata  <= alu_out;
            state_q     <= StMemWr;
          end
        end
        StMemWr: begin
          if (dmem_wr_req && dmem_ack) begin
            dmem_wr_req <= 1'b0;
          end
        end
        default: state_q <= StFetch;
      endcase

      // All commit updates read pre-commit A/PC values.
      if (commit) begin
        if (dest[2]) a_q <= cmt_res;
        if (dest[1]) d_q <= cmt_res;
        pc_q     <= jump ? a_q[ADDR_W-1:0] : pc_inc;
        retire   <= 1'b1;
        imem_req <= 1'b1;
        state_q  <= StFetch;
      end
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
module tb_hack_cpu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_rd_req;
  logic        dmem_wr_req;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctrl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic        retire;
  logic [14:0] pc_o;

  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:32767];

  int total;
  int bad;
  int dmem_wait;
  int dcnt;
  int proto_err;
  logic prev_iack;

  // Scoreboard: expected pushed with stimulus, observed pushed by the port model.
  logic [14:0] exp_rd[$];
  logic [14:0] obs_rd[$];
  logic [30:0] exp_wr[$];
  logic [30:0] obs_wr[$];

  hack_cpu_ctrl #(.RESET_PC(15'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .dmem_rd_req (dmem_rd_req),
    .dmem_wr_req (dmem_wr_req),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_ctrl    (alu_ctrl),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .retire      (retire),
    .pc_o        (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Hack ALU: returns {zr, ng, out}.
  function automatic logic [17:0] alu_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return {(o == 16'h0000), o[15], o};
  endfunction

  assign {alu_zr, alu_ng, alu_out} = alu_model(alu_x, alu_y, alu_ctrl);
  assign imem_rdata = rom[imem_addr];
  assign dmem_rdata = ram[dmem_addr];

  // One clock; observe at the falling edge and drive dmem_ack for the next edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    if (imem_req && prev_iack) proto_err++;
    prev_iack = imem_req && imem_ack;
    if (dmem_rd_req && dmem_wr_req) proto_err++;
    if ((dmem_rd_req || dmem_wr_req) && imem_req) proto_err++;
    if (dmem_rd_req || dmem_wr_req) begin
      dmem_ack = (dcnt >= dmem_wait);
      dcnt++;
    end else begin
      dmem_ack = 1'b0;
      dcnt = 0;
    end
    if (dmem_ack && dmem_rd_req) obs_rd.push_back(dmem_addr);
    if (dmem_ack && dmem_wr_req) begin
      obs_wr.push_back({dmem_addr, dmem_wdata});
      ram[dmem_addr] = dmem_wdata;
    end
  endtask

  // Clock until a retire pulse is seen (bounded); n = cycles taken.
  task automatic run_instr(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!retire && n < 40);
  endtask

  task automatic test_reset();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cycle();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 15'h0000)
      $display("FAIL reset_first_fetch: req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_req_drop: got %b want 0", imem_req);
    end
    total++;
    if (pc_o !== 15'h0000 || alu_x !== 16'h0000 || dmem_addr !== 15'h0000) begin
      bad++;
      $display("FAIL reset_regs: pc=%h d=%h a=%h want 0", pc_o, alu_x, dmem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_iack = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    imem_ack = 1'b1;
    run_instr(n);
    total++;
    if (dmem_addr !== 15'h0005 || pc_o !== 15'h0001) begin
      bad++;
      $display("FAIL basic_ainst: a=%h pc=%h want a=0005 pc=0001", dmem_addr, pc_o);
    end
    run_instr(n);
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL basic_c_latency: got %0d want 3", n);
    end
    total++;
    if (alu_x !== 16'h0005 || dmem_addr !== 15'h0005 || pc_o !== 15'h0002) begin
      bad++;
      $display("FAIL basic_d_eq_a: d=%h a=%h pc=%h want 0005 0005 0002", alu_x, dmem_addr, pc_o);
    end
  endtask

  task automatic test_mem_read();
    int n;
    ram[15'h0010] = 16'h0007;
    dmem_wait = 3;
    exp_rd.push_back(15'h0010);
    run_instr(n);
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL back_to_back_a_latency: got %0d want 2", n);
    end
    run_instr(n);
    total++;
    if (n !== 7) begin
      bad++;
      $display("FAIL mem_read_latency: got %0d want 7", n);
    end
    total++;
    if (alu_x !== 16'h0008 || dmem_addr !== 15'h0010 || pc_o !== 15'h0004) begin
      bad++;
      $display("FAIL mem_read_regs: d=%h a=%h pc=%h want 0008 0010 0004", alu_x, dmem_addr, pc_o);
    end
    while (exp_rd.size() > 0) begin
      logic [14:0] e;
      e = exp_rd.pop_front();
      total++;
      if (obs_rd.size() == 0) begin
        bad++;
        $display("FAIL mem_read_addr: got none want %h", e);
      end else begin
        logic [14:0] o;
        o = obs_rd.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL mem_read_addr: got %h want %h", o, e);
        end
      end
    end
    total++;
    if (proto_err !== 0) begin
      bad++;
      $display("FAIL protocol_mem_read: got %0d violations want 0", proto_err);
    end
  endtask

  task automatic test_mem_write();
    int n;
    dmem_wait = 0;
    exp_wr.push_back({15'h0020, 16'hFFFF});
    run_instr(n);
    run_instr(n);
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL mem_write_latency: got %0d want 4", n);
    end
    total++;
    if (alu_x !== 16'h0008 || dmem_addr !== 15'h0020 || pc_o !== 15'h0006) begin
      bad++;
      $display("FAIL mem_write_regs: d=%h a=%h pc=%h want 0008 0020 0006", alu_x, dmem_addr, pc_o);
    end
    while (exp_wr.size() > 0) begin
      logic [30:0] e;
      e = exp_wr.pop_front();
      total++;
      if (obs_wr.size() == 0) begin
        bad++;
        $display("FAIL mem_write_txn: got none want %h", e);
      end else begin
        logic [30:0] o;
        o = obs_wr.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL mem_write_txn: got %h want %h", o, e);
        end
      end
    end
    total++;
    if (obs_rd.size() !== 0) begin
      bad++;
      $display("FAIL mem_write_no_read: got %0d reads want 0", obs_rd.size());
    end
  endtask

  task automatic test_jump();
    int n;
    repeat (4) run_instr(n);
    total++;
    if (alu_x !== 16'h0000 || pc_o !== 15'h0030) begin
      bad++;
      $display("FAIL jeq_taken: d=%h pc=%h want 0000 0030", alu_x, pc_o);
    end
    repeat (3) run_instr(n);
    total++;
    if (alu_x !== 16'h0001 || pc_o !== 15'h0033) begin
      bad++;
      $display("FAIL jeq_not_taken: d=%h pc=%h want 0001 0033", alu_x, pc_o);
    end
  endtask

  task automatic test_am();
    int n;
    ram[15'h0040] = 16'h0009;
    dmem_wait = 1;
    exp_rd.push_back(15'h0040);
    exp_wr.push_back({15'h0040, 16'h0008});
    run_instr(n);
    run_instr(n);
    total++;
    if (n !== 7) begin
      bad++;
      $display("FAIL am_latency: got %0d want 7", n);
    end
    total++;
    if (dmem_addr !== 15'h0008 || alu_x !== 16'h0001 || pc_o !== 15'h0035) begin
      bad++;
      $display("FAIL am_regs: a=%h d=%h pc=%h want 0008 0001 0035", dmem_addr, alu_x, pc_o);
    end
    while (exp_rd.size() > 0) begin
      logic [14:0] e;
      e = exp_rd.pop_front();
      total++;
      if (obs_rd.size() == 0) begin
        bad++;
        $display("FAIL am_read_addr: got none want %h", e);
      end else begin
        logic [14:0] o;
        o = obs_rd.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL am_read_addr: got %h want %h", o, e);
        end
      end
    end
    while (exp_wr.size() > 0) begin
      logic [30:0] e;
      e = exp_wr.pop_front();
      total++;
      if (obs_wr.size() == 0) begin
        bad++;
        $display("FAIL am_write_txn: got none want %h", e);
      end else begin
        logic [30:0] o;
        o = obs_wr.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL am_write_txn: got %h want %h", o, e);
        end
      end
    end
    dmem_wait = 0;
  endtask

  task automatic test_pc_wrap();
    int n;
    run_instr(n);
    run_instr(n);
    total++;
    if (pc_o !== 15'h7FFF) begin
      bad++;
      $display("FAIL jmp_to_top: got %h want 7fff", pc_o);
    end
    run_instr(n);
    total++;
    if (pc_o !== 15'h0000 || dmem_addr !== 15'h0003) begin
      bad++;
      $display("FAIL pc_wrap: pc=%h a=%h want 0000 0003", pc_o, dmem_addr);
    end
    total++;
    if (proto_err !== 0) begin
      bad++;
      $display("FAIL protocol_total: got %0d violations want 0", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    run_instr(n);
    imem_ack = 1'b0;
    cycle();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 15'h0001 || alu_x !== 16'h0001) begin
      bad++;
      $display("FAIL pre_reset: req=%b pc=%h d=%h want 1 0001 0001", imem_req, imem_addr, alu_x);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || retire !== 1'b0 || alu_ctrl !== 6'h00) begin
      bad++;
      $display("FAIL reset_mid_outputs: req=%b ret=%b ctrl=%h want 0 0 00", imem_req, retire,
               alu_ctrl);
    end
    total++;
    if (pc_o !== 15'h0000 || alu_x !== 16'h0000 || dmem_addr !== 15'h0000) begin
      bad++;
      $display("FAIL reset_mid_regs: pc=%h d=%h a=%h want 0", pc_o, alu_x, dmem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_iack = 1'b0;
    cycle();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 15'h0000) begin
      bad++;
      $display("FAIL reset_mid_refetch: req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    dmem_wait = 0;
    dcnt = 0;
    proto_err = 0;
    prev_iack = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst_n = 1'b0;
    rom[15'h0000] = 16'h0005;  // @5
    rom[15'h0001] = 16'hEC10;  // D=A
    rom[15'h0002] = 16'h0010;  // @16
    rom[15'h0003] = 16'hFDD0;  // D=M+1
    rom[15'h0004] = 16'h0020;  // @32
    rom[15'h0005] = 16'hEE88;  // M=-1
    rom[15'h0006] = 16'h0000;  // @0
    rom[15'h0007] = 16'hEC10;  // D=A
    rom[15'h0008] = 16'h0030;  // @48
    rom[15'h0009] = 16'hEA82;  // 0;JEQ
    rom[15'h0030] = 16'h0001;  // @1
    rom[15'h0031] = 16'hEC10;  // D=A
    rom[15'h0032] = 16'hE302;  // D;JEQ
    rom[15'h0033] = 16'h0040;  // @64
    rom[15'h0034] = 16'hFCA8;  // AM=M-1
    rom[15'h0035] = 16'h7FFF;  // @32767
    rom[15'h0036] = 16'hEA87;  // 0;JMP
    rom[15'h7FFF] = 16'h0003;  // @3
    test_reset();
    test_basic();
    test_mem_read();
    test_mem_write();
    test_jump();
    test_am();
    test_pc_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
